// File: rtl/stack_pkg.sv
// Shared definitions for the data-stack controller: RAM stackOp encodings,
// controller FSM states and the stack depth derivation.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } stackOp_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PUSH_WR = 2'b01,
        POP_RD  = 2'b10,
        POP_RSP = 2'b11
    } state_e;

    function automatic int depthOf(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Request/response handshake between the control unit (master) and the
// stack controller (slave): req_valid/req_ready/req_op/req_data, rsp_valid/rsp_data.
interface stack_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/stack_ptr_counter.sv
// Stack pointer register with increment/decrement and full/empty compare.
// Ports: clock, reset_n, inc, dec in; sp, full, empty out. SP saturates at 0..DEPTH.
module stack_ptr_counter
    import stack_pkg::*;
#(
    parameter int STACK_BITS = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              dec,
    output logic [STACK_BITS:0] sp,
    output logic              full,
    output logic              empty
);
    localparam logic [STACK_BITS:0] DEPTH_V =
        (STACK_BITS+1)'(depthOf(STACK_BITS));

    assign full  = (sp == DEPTH_V);
    assign empty = (sp == '0);

    // Guards keep SP from wrapping even if a caller misbehaves.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (inc && !full) begin
            sp <= sp + 1'b1;
        end else if (dec && !empty) begin
            sp <= sp - 1'b1;
        end
    end
endmodule

// File: rtl/stack_controller.sv
// Sequences the stack RAM: turns push/pop(/peek) requests into RAM stackPointer/stackOp/data.
// Ports: clock, reset_n, bus (slave handshake), mem_* RAM side, depth/full/empty, err_* pulses.
// Optional: define STACK_PEEK_EN to make req_op 11 a non-destructive PEEK (else NOP).
module stack_controller
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STACK_BITS = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    stack_controller_if.slave     bus,
    output logic [DATA_WIDTH-1:0] mem_sp,
    output logic [1:0]            mem_op,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [STACK_BITS:0]   depth,
    output logic                  full,
    output logic                  empty,
    output logic                  err_overflow,
    output logic                  err_underflow
);
    state_e              state;
    logic                isPeek;
    logic                pushReq;
    logic                popReq;
    logic                peekReq;
    logic [STACK_BITS:0] sp;

    stack_ptr_counter #(.STACK_BITS(STACK_BITS)) u_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (state == PUSH_WR),
        .dec     (state == POP_RSP && !isPeek),
        .sp      (sp),
        .full    (full),
        .empty   (empty)
    );

    assign depth         = sp;
    assign mem_sp        = DATA_WIDTH'(sp);
    assign bus.req_ready = (state == IDLE);

    always_comb begin
        peekReq = 1'b0;
`ifdef STACK_PEEK_EN
        peekReq = bus.req_valid && (bus.req_op == OP_PEEK);
`endif
        pushReq = bus.req_valid && (bus.req_op == OP_PUSH);
        popReq  = (bus.req_valid && (bus.req_op == OP_POP)) || peekReq;
    end

    // mem_op is cleared asynchronously so a pending PUSH_WR write never lands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            isPeek        <= 1'b0;
            mem_op        <= OP_NOP;
            mem_wdata     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        pushReq: begin
                            if (full) begin
                                err_overflow <= 1'b1;
                            end else begin
                                mem_wdata <= bus.req_data;
                                mem_op    <= OP_PUSH;
                                state     <= PUSH_WR;
                            end
                        end
                        popReq: begin
                            if (empty) begin
                                bus.rsp_valid <= 1'b1;
                                bus.rsp_data  <= '0;
                                err_underflow <= 1'b1;
                            end else begin
                                isPeek <= peekReq;
                                mem_op <= OP_POP;
                                state  <= POP_RD;
                            end
                        end
                        default: ;
                    endcase
                end
                PUSH_WR: begin
                    mem_op <= OP_NOP;
                    state  <= IDLE;
                end
                // RAM registers STACK[SP-1] at the end of this cycle.
                POP_RD: begin
                    state <= POP_RSP;
                end
                // mem_op stays POP here so the RAM output is not gated.
                POP_RSP: begin
                    bus.rsp_data  <= mem_rdata;
                    bus.rsp_valid <= 1'b1;
                    mem_op        <= OP_NOP;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_controller.sv
// Directed self-checking bench for stack_controller with a 4-entry RAM model.
// Honours STACK_PEEK_EN the same way as the design.
module tb_stack_controller;
    localparam int DW = 32;
    localparam int SB = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] mem_sp;
    logic [1:0]    mem_op;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [SB:0]   depth;
    logic          full;
    logic          empty;
    logic          err_overflow;
    logic          err_underflow;

    int total = 0;
    int fails = 0;

    stack_controller_if #(.DATA_WIDTH(DW)) bus ();

    stack_controller #(.DATA_WIDTH(DW), .STACK_BITS(SB)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .mem_sp        (mem_sp),
        .mem_op        (mem_op),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .depth         (depth),
        .full          (full),
        .empty         (empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clock = ~clock;

    // Stack RAM model: write STACK[SP] on op 01, register STACK[SP-1] on op 10,
    // output gated to zero unless op is 10.
    logic [DW-1:0] ram [4];
    logic [DW-1:0] rdq;
    logic [1:0]    rdIdx;
    assign rdIdx     = mem_sp[1:0] - 2'd1;
    assign mem_rdata = (mem_op == 2'b10) ? rdq : '0;

    always @(posedge clock) begin
        if (mem_op == 2'b01) ram[mem_sp[1:0]] <= mem_wdata;
        if (mem_op == 2'b10) rdq <= ram[rdIdx];
    end

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitReady();
        for (int i = 0; i < 8 && bus.req_ready !== 1'b1; i++)
            @(negedge clock);
        check("ready", DW'(bus.req_ready), 1);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic expOv);
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_data  = d;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        check("overflow", DW'(err_overflow), DW'(expOv));
        waitReady();
    endtask

    task automatic pop(input logic [1:0] op, input logic [DW-1:0] exp,
                       input logic expUn);
        logic seen;
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("rspSeen", DW'(seen), 1);
        check("rspData", bus.rsp_data, exp);
        check("underflow", DW'(err_underflow), DW'(expUn));
    endtask

    initial begin
        logic [DW-1:0] old;
        logic          seen;
        for (int i = 0; i < 4; i++) ram[i] = '0;
        rdq           = '0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = '0;

        repeat (2) @(negedge clock);
        check("rstMemOp", DW'(mem_op), 0);
        check("rstWdata", mem_wdata, 0);
        check("rstRsp", DW'(bus.rsp_valid), 0);
        check("rstReady", DW'(bus.req_ready), 1);
        reset_n = 1'b1;
        @(negedge clock);
        check("rstDepth", DW'(depth), 0);
        check("rstEmpty", DW'(empty), 1);
        check("rstFull", DW'(full), 0);

        // Pop on empty stack
        pop(2'b10, 0, 1'b1);
        check("unDepth", DW'(depth), 0);

        // LIFO order
        push(32'hA, 1'b0);
        check("depth1", DW'(depth), 1);
        push(32'hB, 1'b0);
        push(32'hC, 1'b0);
        check("depth3", DW'(depth), 3);
        pop(2'b10, 32'hC, 1'b0);
        pop(2'b10, 32'hB, 1'b0);
        pop(2'b10, 32'hA, 1'b0);
        check("depth0", DW'(depth), 0);
        check("emptyEnd", DW'(empty), 1);

        // Fill and overflow
        push(32'h1, 1'b0);
        push(32'h2, 1'b0);
        push(32'h3, 1'b0);
        check("notFull3", DW'(full), 0);
        push(32'h4, 1'b0);
        check("full4", DW'(full), 1);
        check("depth4", DW'(depth), 4);
        push(32'hFF, 1'b1);
        check("ovfDepth", DW'(depth), 4);
        pop(2'b10, 32'h4, 1'b0);
        check("notFull", DW'(full), 0);
        pop(2'b10, 32'h3, 1'b0);
        pop(2'b10, 32'h2, 1'b0);
        pop(2'b10, 32'h1, 1'b0);
        check("emptyAgain", DW'(empty), 1);

        // Back-to-back pushes with valid held
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_data  = 32'h11;
        check("b2bReady0", DW'(bus.req_ready), 1);
        @(negedge clock);
        check("b2bReady1", DW'(bus.req_ready), 0);
        bus.req_data = 32'h22;
        @(negedge clock);
        check("b2bReady2", DW'(bus.req_ready), 1);
        @(negedge clock);
        check("b2bReady3", DW'(bus.req_ready), 0);
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("b2bDepth", DW'(depth), 2);
        pop(2'b10, 32'h22, 1'b0);
        pop(2'b10, 32'h11, 1'b0);

        // Op 11
`ifdef STACK_PEEK_EN
        push(32'h5, 1'b0);
        pop(2'b11, 32'h5, 1'b0);
        pop(2'b11, 32'h5, 1'b0);
        check("peekDepth", DW'(depth), 1);
        pop(2'b10, 32'h5, 1'b0);
`else
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b11;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("op11NoRsp", DW'(seen), 0);
        check("op11Ready", DW'(bus.req_ready), 1);
`endif
        check("preRstDepth", DW'(depth), 0);

        // Reset during PUSH_WR
        old = ram[0];
        waitReady();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_data  = 32'h77;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        check("pushWrOp", DW'(mem_op), 1);
        reset_n = 1'b0;
        #1;
        check("rstAbortOp", DW'(mem_op), 0);
        check("rstAbortReady", DW'(bus.req_ready), 1);
        @(posedge clock);
        #1;
        check("noRamWrite", ram[0], old);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rstAbortDepth", DW'(depth), 0);
        check("rstAbortRsp", DW'(bus.rsp_valid), 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
